// File: rtl/ahbl_slave_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ahbl_slave_rr_arbiter
//   Address-phase arbiter for one slave port of the 4-master AHB-Lite matrix.
//   Produces a registered one-hot grant used by the slave stage to mux the
//   selected master's address-phase signals. Round-robin scheduling with a
//   per-owner quantum; HMASTLOCK sequences keep the current owner.
//
//   Optional feature macro: AHBL_ARB_BURST_HOLD_EN
//     When defined, the MBURSTACT port exists and an owner with pending burst
//     beats keeps the grant regardless of the quantum.
//
// Parameters
//   QUANTUM   max consecutive address phases per owner while others wait (1..15)
//   INIT_PTR  reset value of the round-robin pointer (search starts at +1)
//
// Ports
//   HCLK             in   clock
//   HRESET           in   asynchronous active-high reset
//   MADDRSEL[3:0]    in   per-master request (address decodes to this slave)
//   MASTLOCK[3:0]    in   per-master gated HMASTLOCK
//   ADDRPHEND        in   slave HREADYOUT; state only advances when high
//   MBURSTACT[3:0]   in   (macro only) master has further burst beats pending
//   MASTERADDRINPROG out  registered one-hot grant, 0 = no owner
//   ARB_STATE[1:0]   out  00 IDLE, 01 OWNED, 10 LOCKED
//   QCOUNT[3:0]      out  phases granted to current owner minus 1 (saturating)
// ---------------------------------------------------------------------------
module ahbl_slave_rr_arbiter #(
  parameter int unsigned QUANTUM  = 4,
  parameter logic [1:0]  INIT_PTR = 2'd3
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic [3:0] MADDRSEL,
  input  logic [3:0] MASTLOCK,
  input  logic       ADDRPHEND,
`ifdef AHBL_ARB_BURST_HOLD_EN
  input  logic [3:0] MBURSTACT,
`endif
  output logic [3:0] MASTERADDRINPROG,
  output logic [1:0] ARB_STATE,
  output logic [3:0] QCOUNT
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_OWNED  = 2'b01,
    ST_LOCKED = 2'b10
  } arb_state_e;

  localparam logic [3:0] QMAX = 4'(QUANTUM - 1);

  logic [3:0] grant_q, grant_d;
  arb_state_e state_q, state_d;
  logic [3:0] qcnt_q, qcnt_d;
  logic [1:0] ptr_q, ptr_d;

  logic       g_valid;
  logic [1:0] g_idx;
  logic [3:0] qcnt_sat;
  logic       hit;
  logic [1:0] h_idx;
  logic [1:0] cand;
  logic       burst_hold;

  // Current owner index from the one-hot grant.
  always_comb begin
    g_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (grant_q[i]) g_idx = 2'(i);
    end
  end

  assign g_valid  = |grant_q;
  assign qcnt_sat = (qcnt_q >= QMAX) ? QMAX : qcnt_q + 4'd1;

`ifdef AHBL_ARB_BURST_HOLD_EN
  assign burst_hold = g_valid & MBURSTACT[g_idx];
`else
  assign burst_hold = 1'b0;
`endif

  // Round-robin search starting one past the pointer; i==4 wraps to ptr itself,
  // so the last-served master is considered last.
  always_comb begin
    hit   = 1'b0;
    h_idx = ptr_q;
    cand  = ptr_q;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!hit && MADDRSEL[cand]) begin
        hit   = 1'b1;
        h_idx = cand;
      end
    end
  end

  always_comb begin
    grant_d = grant_q;
    state_d = state_q;
    qcnt_d  = qcnt_q;
    ptr_d   = ptr_q;
    if (ADDRPHEND) begin
      if (g_valid && MASTLOCK[g_idx]) begin
        state_d = ST_LOCKED;
        qcnt_d  = qcnt_sat;
      end else if (burst_hold) begin
        state_d = ST_OWNED;
        qcnt_d  = qcnt_sat;
      end else if (g_valid && MADDRSEL[g_idx] && (qcnt_q < QMAX)) begin
        state_d = ST_OWNED;
        qcnt_d  = qcnt_q + 4'd1;
      end else if (hit) begin
        grant_d = 4'b0001 << h_idx;
        ptr_d   = h_idx;
        state_d = ST_OWNED;
        // Re-selecting the same owner means nobody else is waiting.
        qcnt_d  = (g_valid && (h_idx == g_idx)) ? QMAX : '0;
      end else begin
        grant_d = '0;
        state_d = ST_IDLE;
        qcnt_d  = '0;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      grant_q <= '0;
      state_q <= ST_IDLE;
      qcnt_q  <= '0;
      ptr_q   <= INIT_PTR;
    end else begin
      grant_q <= grant_d;
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign MASTERADDRINPROG = grant_q;
  assign ARB_STATE        = state_q;
  assign QCOUNT           = qcnt_q;

endmodule

// File: tb/tb_ahbl_slave_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahbl_slave_rr_arbiter
//   Self-checking bench for ahbl_slave_rr_arbiter (QUANTUM=4, INIT_PTR=3).
//   A behavioural model tracks owner/phase-count/pointer as integers; a
//   compare process checks every falling edge, and directed scenarios add
//   literal expectations. Build with +define+AHBL_ARB_BURST_HOLD_EN to
//   exercise the burst-hold variant.
// ---------------------------------------------------------------------------
module tb_ahbl_slave_rr_arbiter;

  localparam int Q = 4;
`ifdef AHBL_ARB_BURST_HOLD_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] MADDRSEL;
  logic [3:0] MASTLOCK;
  logic       ADDRPHEND;
  logic [3:0] MBURSTACT;
  logic [3:0] MASTERADDRINPROG;
  logic [1:0] ARB_STATE;
  logic [3:0] QCOUNT;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 HCLK = ~HCLK;

  ahbl_slave_rr_arbiter #(
    .QUANTUM (4),
    .INIT_PTR(2'd3)
  ) dut (
    .HCLK            (HCLK),
    .HRESET          (HRESET),
    .MADDRSEL        (MADDRSEL),
    .MASTLOCK        (MASTLOCK),
    .ADDRPHEND       (ADDRPHEND),
`ifdef AHBL_ARB_BURST_HOLD_EN
    .MBURSTACT       (MBURSTACT),
`endif
    .MASTERADDRINPROG(MASTERADDRINPROG),
    .ARB_STATE       (ARB_STATE),
    .QCOUNT          (QCOUNT)
  );

  // ---------------- behavioural model ----------------
  int m_owner;   // -1 = none
  int m_cnt;     // phases granted to owner minus one
  int m_ptr;
  bit m_locked;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      m_owner = -1; m_cnt = 0; m_ptr = 3; m_locked = 0;
    end else if (ADDRPHEND) begin
      if (m_owner >= 0 && MASTLOCK[m_owner]) begin
        m_locked = 1;
        m_cnt = (m_cnt + 1 > Q - 1) ? Q - 1 : m_cnt + 1;
      end else if (BURST && m_owner >= 0 && MBURSTACT[m_owner]) begin
        m_locked = 0;
        m_cnt = (m_cnt + 1 > Q - 1) ? Q - 1 : m_cnt + 1;
      end else if (m_owner >= 0 && MADDRSEL[m_owner] && m_cnt < Q - 1) begin
        m_locked = 0;
        m_cnt++;
      end else begin
        int h;
        h = -1;
        for (int k = 1; k <= 4; k++) begin
          if (h < 0 && MADDRSEL[(m_ptr + k) % 4]) h = (m_ptr + k) % 4;
        end
        m_locked = 0;
        if (h < 0) begin
          m_owner = -1; m_cnt = 0;
        end else begin
          m_cnt   = (h == m_owner) ? Q - 1 : 0;
          m_owner = h;
          m_ptr   = h;
        end
      end
    end
  end

  function automatic int exp_grant();
    return (m_owner < 0) ? 0 : (1 << m_owner);
  endfunction

  function automatic int exp_state();
    return (m_owner < 0) ? 0 : (m_locked ? 2 : 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge HCLK) begin
    chk("model_grant", int'(MASTERADDRINPROG), exp_grant());
    chk("model_state", int'(ARB_STATE), exp_state());
    chk("model_qcount", int'(QCOUNT), (m_owner < 0) ? 0 : m_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge HCLK);
    @(negedge HCLK);
    #1;
  endtask

  task automatic clear_inputs();
    MADDRSEL = '0; MASTLOCK = '0; MBURSTACT = '0; ADDRPHEND = 1'b1;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    #1;
    HRESET = 1'b0;
  endtask

  typedef struct {
    logic [3:0] sel;
    logic [3:0] lock;
    logic       rdy;
  } vec_t;

  vec_t vecs[16] = '{
    '{4'b1010, 4'b0000, 1'b1}, '{4'b1010, 4'b0000, 1'b1},
    '{4'b1010, 4'b0000, 1'b0}, '{4'b1000, 4'b0000, 1'b1},
    '{4'b1000, 4'b1000, 1'b1}, '{4'b0000, 4'b1000, 1'b1},
    '{4'b0001, 4'b0000, 1'b1}, '{4'b0000, 4'b0000, 1'b1},
    '{4'b0110, 4'b0000, 1'b1}, '{4'b0110, 4'b0000, 1'b1},
    '{4'b0110, 4'b0000, 1'b1}, '{4'b0110, 4'b0000, 1'b1},
    '{4'b0110, 4'b0000, 1'b1}, '{4'b0100, 4'b0000, 1'b1},
    '{4'b0100, 4'b0000, 1'b1}, '{4'b0000, 4'b0000, 1'b0}
  };

  initial begin
    HRESET = 1'b1;
    clear_inputs();
    #1;
    chk("reset_grant", int'(MASTERADDRINPROG), 0);
    chk("reset_state", int'(ARB_STATE), 0);
    #11;
    HRESET = 1'b0;

    // mid-transfer asynchronous reset while master 2 owns the slave
    MADDRSEL = 4'b0100;
    step();
    chk("pre_reset_grant", int'(MASTERADDRINPROG), 4'b0100);
    MADDRSEL = '0;
    HRESET = 1'b1;
    #1;
    chk("async_reset_grant", int'(MASTERADDRINPROG), 0);
    chk("async_reset_state", int'(ARB_STATE), 0);
    chk("async_reset_qcount", int'(QCOUNT), 0);
    HRESET = 1'b0;

    // single requester
    do_reset();
    MADDRSEL = 4'b0010;
    step();
    chk("single_grant", int'(MASTERADDRINPROG), 4'b0010);
    chk("single_state", int'(ARB_STATE), 1);
    MADDRSEL = 4'b0000;
    step();
    chk("single_release", int'(MASTERADDRINPROG), 0);
    chk("single_idle", int'(ARB_STATE), 0);

    // round-robin with quantum 4
    clear_inputs();
    do_reset();
    MADDRSEL = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      step();
      chk("rr_grant", int'(MASTERADDRINPROG), 1 << ((i / 4) % 4));
      chk("rr_qcount", int'(QCOUNT), i % 4);
    end

    // stall: nothing moves while ADDRPHEND is low
    ADDRPHEND = 1'b0;
    MADDRSEL  = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_grant", int'(MASTERADDRINPROG), 4'b0001);
      chk("stall_qcount", int'(QCOUNT), 0);
    end
    ADDRPHEND = 1'b1;
    step();
    chk("stall_resume", int'(MASTERADDRINPROG), 4'b0010);

    // locked sequence, request dropped partway through the lock
    clear_inputs();
    do_reset();
    MADDRSEL = 4'b1111;
    step();
    MASTLOCK = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) MADDRSEL = 4'b1110;
      step();
    end
    chk("lock_grant", int'(MASTERADDRINPROG), 4'b0001);
    chk("lock_state", int'(ARB_STATE), 2);
    chk("lock_qcount", int'(QCOUNT), 3);
    MASTLOCK = '0;
    MADDRSEL = 4'b1111;
    step();
    chk("unlock_grant", int'(MASTERADDRINPROG), 4'b0010);
    chk("unlock_state", int'(ARB_STATE), 1);
    chk("unlock_qcount", int'(QCOUNT), 0);

    // burst hold (only effective with the macro defined)
    clear_inputs();
    do_reset();
    MADDRSEL  = 4'b1111;
    MBURSTACT = 4'b0001;
    for (int i = 0; i < 8; i++) step();
    chk("burst_grant8", int'(MASTERADDRINPROG), BURST ? 4'b0001 : 4'b0010);
    chk("burst_qcount8", int'(QCOUNT), 3);
    MBURSTACT = '0;
    step();
    chk("burst_drop", int'(MASTERADDRINPROG), BURST ? 4'b0010 : 4'b0100);

    // mixed directed vectors, checked by the model
    clear_inputs();
    do_reset();
    foreach (vecs[i]) begin
      MADDRSEL  = vecs[i].sel;
      MASTLOCK  = vecs[i].lock;
      ADDRPHEND = vecs[i].rdy;
      step();
    end
    // after vectors: 0010 granted first, 1000 locked then released,
    // 0001 single, idle, then 0100/0010 alternation; last grant stays 0100
    chk("vec_end_grant", int'(MASTERADDRINPROG), 4'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
